spell_sequencer: RTL and testbench

Multi-cycle control/state stage directly upstream of spell_execute in the Spell stack CPU.
- Owns pc, sp and the 32x8 stack register file.
- Fetches opcodes and operand bytes through one shared memory port and presents the architectural state to the combinational execute stage.
- Commits the execute results, then performs memory writes, delays and sleep.

---
 rtl/spell_sequencer.sv | 176 +++++++++++++++++
 tb/tb_spell_sequencer.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spell_sequencer.sv
// Spell CPU control stage: owns pc/sp/stack, fetches opcode+operand, commits execute results, then write/delay/sleep.
// Access states hold all request fields until mem_ack (2 cycles at zero-wait); EXEC is always exactly one cycle.
module spell_sequencer #(
  parameter int         DELAY_CYCLES = 16,
  parameter logic [7:0] OP_CODE_READ = 8'h3F,
  parameter logic [7:0] OP_DATA_READ = 8'h72
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       step,
  input  logic       wake,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_type_data,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ack,
  output logic [7:0] exec_opcode,
  output logic [7:0] exec_pc,
  output logic [4:0] exec_sp,
  output logic [7:0] exec_stack_top,
  output logic [7:0] exec_stack_belowtop,
  output logic [7:0] exec_memory_input,
  input  logic [7:0] next_pc,
  input  logic [4:0] next_sp,
  input  logic [1:0] stack_write_count,
  input  logic [7:0] set_stack_top,
  input  logic [7:0] set_stack_belowtop,
  input  logic       memory_write_en,
  input  logic       memory_write_type_data,
  input  logic [7:0] memory_write_addr,
  input  logic [7:0] memory_write_data,
  input  logic [7:0] delay_amount,
  input  logic       sleep,
  output logic       busy,
  output logic       sleeping,
  output logic [7:0] pc,
  output logic [4:0] sp
);

  localparam int            PW        = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DELAY_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_READ, S_EXEC, S_WRITE, S_DELAY, S_SLEEP
  } state_t;

  state_t        state_q, state_d, end_state;
  logic [7:0]    pc_q, opcode_q, operand_q;
  logic [4:0]    sp_q;
  logic          step_q;
  logic          wr_type_q;
  logic [7:0]    wr_addr_q, wr_data_q;
  logic [7:0]    unit_q;
  logic [PW-1:0] presc_q;
  logic [7:0]    stack_mem [0:31];
  logic          delay_done;

  assign exec_opcode         = opcode_q;
  assign exec_pc             = pc_q;
  assign exec_sp             = sp_q;
  assign exec_stack_top      = stack_mem[sp_q - 5'd1];
  assign exec_stack_belowtop = stack_mem[sp_q - 5'd2];
  assign exec_memory_input   = operand_q;
  assign pc                  = pc_q;
  assign sp                  = sp_q;

  assign delay_done = (presc_q == PRESC_MAX) && (unit_q == 8'd1);

  // END is folded into every transition that would reach it.
  always_comb begin
    end_state = (run && !step_q) ? S_FETCH : S_IDLE;
    state_d   = state_q;
    case (state_q)
      S_IDLE:  if (run || step) state_d = S_FETCH;
      S_FETCH: if (mem_ack)
                 state_d = (mem_rdata == OP_CODE_READ || mem_rdata == OP_DATA_READ) ? S_READ : S_EXEC;
      S_READ:  if (mem_ack) state_d = S_EXEC;
      S_EXEC: begin
        if (memory_write_en)          state_d = S_WRITE;
        else if (delay_amount != 8'd0) state_d = S_DELAY;
        else if (sleep)               state_d = S_SLEEP;
        else                          state_d = end_state;
      end
      S_WRITE: if (mem_ack) state_d = end_state;
      S_DELAY: if (delay_done) state_d = end_state;
      S_SLEEP: begin
        if (!run && !step_q) state_d = S_IDLE;
        else if (wake)       state_d = end_state;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= 8'd0;
      sp_q      <= 5'd0;
      opcode_q  <= 8'd0;
      operand_q <= 8'd0;
      step_q    <= 1'b0;
      wr_type_q <= 1'b0;
      wr_addr_q <= 8'd0;
      wr_data_q <= 8'd0;
      unit_q    <= 8'd0;
      presc_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE:  if (run || step) step_q <= step & ~run;
        S_FETCH: if (mem_ack) opcode_q <= mem_rdata;
        S_READ:  if (mem_ack) operand_q <= mem_rdata;
        S_EXEC: begin
          pc_q      <= next_pc;
          sp_q      <= next_sp;
          wr_type_q <= memory_write_type_data;
          wr_addr_q <= memory_write_addr;
          wr_data_q <= memory_write_data;
          unit_q    <= delay_amount;
          presc_q   <= '0;
        end
        S_DELAY: begin
          if (presc_q == PRESC_MAX) begin
            presc_q <= '0;
            unit_q  <= unit_q - 8'd1;
          end else begin
            presc_q <= presc_q + PW'(1);
          end
        end
        default: ;
      endcase
      if (state_d == S_IDLE) step_q <= 1'b0;
    end
  end

  // Stack storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (rst_n && state_q == S_EXEC) begin
      if (stack_write_count != 2'd0) stack_mem[next_sp - 5'd1] <= set_stack_top;
      if (stack_write_count[1])      stack_mem[next_sp - 5'd2] <= set_stack_belowtop;
    end
  end

  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_type_data = 1'b0;
    mem_addr      = 8'd0;
    mem_wdata     = 8'd0;
    case (state_q)
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
      end
      S_READ: begin
        mem_req       = 1'b1;
        mem_type_data = (opcode_q == OP_DATA_READ);
        mem_addr      = exec_stack_top;
      end
      S_WRITE: begin
        mem_req       = 1'b1;
        mem_we        = 1'b1;
        mem_type_data = wr_type_q;
        mem_addr      = wr_addr_q;
        mem_wdata     = wr_data_q;
      end
      default: ;
    endcase
    busy     = (state_q != S_IDLE) && (state_q != S_SLEEP);
    sleeping = (state_q == S_SLEEP);
  end

endmodule

// File: tb/tb_spell_sequencer.sv
// Directed bench for spell_sequencer with a latency-configurable memory responder and a simple execute stub.
module tb_spell_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0, run = 1'b0, step = 1'b0, wake = 1'b0;
  logic       mem_req, mem_we, mem_type_data;
  logic [7:0] mem_addr, mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_ack;
  logic [7:0] exec_opcode, exec_pc, exec_stack_top, exec_stack_belowtop, exec_memory_input;
  logic [4:0] exec_sp;
  logic [7:0] next_pc;
  logic [4:0] next_sp;
  logic       busy, sleeping;
  logic [7:0] pc;
  logic [4:0] sp;

  // execute stub configuration
  logic [4:0] sp_inc    = 5'd1;
  logic [1:0] st_wcount = 2'd1;
  logic       top_sel   = 1'b0;
  logic [7:0] bt_val    = 8'hEE;
  logic       st_mwe    = 1'b0;
  logic       st_wtype  = 1'b0;
  logic [7:0] st_waddr  = 8'h00;
  logic [7:0] st_wdata  = 8'h00;
  logic [7:0] st_delay  = 8'h00;
  logic       st_sleep  = 1'b0;

  assign next_pc = exec_pc + 8'd1;
  assign next_sp = exec_sp + sp_inc;

  // memory model
  logic [7:0] code_mem [0:255];
  logic [7:0] data_mem [0:255];
  int         wr_lat    = 1;
  logic       ack_block = 1'b0;
  logic       stray_ack = 1'b0;
  int         age       = 0;

  int checks = 0;
  int errors = 0;

  spell_sequencer #(.DELAY_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .wake(wake),
    .mem_req(mem_req), .mem_we(mem_we), .mem_type_data(mem_type_data),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .exec_opcode(exec_opcode), .exec_pc(exec_pc), .exec_sp(exec_sp),
    .exec_stack_top(exec_stack_top), .exec_stack_belowtop(exec_stack_belowtop),
    .exec_memory_input(exec_memory_input),
    .next_pc(next_pc), .next_sp(next_sp), .stack_write_count(st_wcount),
    .set_stack_top(top_sel ? exec_memory_input : exec_opcode),
    .set_stack_belowtop(bt_val), .memory_write_en(st_mwe),
    .memory_write_type_data(st_wtype), .memory_write_addr(st_waddr),
    .memory_write_data(st_wdata), .delay_amount(st_delay), .sleep(st_sleep),
    .busy(busy), .sleeping(sleeping), .pc(pc), .sp(sp)
  );

  // Reads ack on the 2nd request cycle; writes ack after wr_lat waiting cycles.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (mem_ack) age = 0;
      mem_ack = 1'b0;
      if (stray_ack) begin
        mem_ack   = 1'b1;
        mem_rdata = 8'h72;
      end else if (mem_req && !ack_block) begin
        age++;
        if (age > (mem_we ? wr_lat : 1)) begin
          mem_ack = 1'b1;
          if (mem_we) begin
            if (mem_type_data) data_mem[mem_addr] = mem_wdata;
            else               code_mem[mem_addr] = mem_wdata;
          end else begin
            mem_rdata = mem_type_data ? data_mem[mem_addr] : code_mem[mem_addr];
          end
        end
      end else if (!mem_req) begin
        age = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; step = 1'b0; wake = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while ((busy || sleeping) && n < limit) begin
      tick();
      n++;
    end
    checks++;
    if (busy || sleeping) begin
      errors++;
      $display("FAIL idle_timeout: busy=%b sleeping=%b after %0d cycles, required 0/0", busy, sleeping, n);
    end
  endtask

  // One step pulse; reports busy cycles and request cycles of that instruction.
  task automatic do_step(output int nb, output int nr);
    nb = 0; nr = 0;
    step = 1'b1;
    tick();
    step = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      nb++;
      if (mem_req) nr++;
      tick();
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL step_timeout: still busy after 200 cycles, required idle");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if ({mem_req, mem_we, mem_type_data, mem_addr, mem_wdata} !== 19'd0) begin
      errors++;
      $display("FAIL reset_mem: got %b/%b/%b/%h/%h, required all zero", mem_req, mem_we, mem_type_data, mem_addr, mem_wdata);
    end
    checks++;
    if ({pc, sp, exec_pc, exec_sp, exec_opcode, exec_memory_input} !== 42'd0) begin
      errors++;
      $display("FAIL reset_state: pc=%h sp=%h opcode=%h operand=%h, required 0", pc, sp, exec_opcode, exec_memory_input);
    end
    checks++;
    if ({busy, sleeping} !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle: busy=%b sleeping=%b, required 0/0", busy, sleeping);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_run_basic();
    code_mem[0] = 8'h41; code_mem[1] = 8'h01;
    do_reset();
    run = 1'b1;
    tick();
    checks++;
    if ({mem_req, mem_we, mem_type_data, mem_addr} !== {3'b100, 8'h00}) begin
      errors++;
      $display("FAIL fetch_c1: req/we/type/addr=%b%b%b/%h, required 100/00", mem_req, mem_we, mem_type_data, mem_addr);
    end
    tick();
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL fetch_hold: mem_req=%b, required 1", mem_req);
    end
    tick();
    checks++;
    if ({mem_req, busy, exec_opcode} !== {2'b01, 8'h41}) begin
      errors++;
      $display("FAIL exec_c3: req=%b busy=%b opcode=%h, required 0/1/41", mem_req, busy, exec_opcode);
    end
    tick();
    checks++;
    if ({pc, sp, exec_stack_top} !== {8'h01, 5'd1, 8'h41}) begin
      errors++;
      $display("FAIL commit: pc=%h sp=%h top=%h, required 01/01/41", pc, sp, exec_stack_top);
    end
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 8'h01}) begin
      errors++;
      $display("FAIL fetch_next: req=%b addr=%h, required 1/01", mem_req, mem_addr);
    end
    run = 1'b0;
    wait_idle(20);
    checks++;
    if ({pc, sp, exec_stack_top, exec_stack_belowtop} !== {8'h02, 5'd2, 8'h01, 8'h41}) begin
      errors++;
      $display("FAIL run_drop: pc=%h sp=%h top=%h below=%h, required 02/02/01/41", pc, sp, exec_stack_top, exec_stack_belowtop);
    end
  endtask

  task automatic test_read();
    int nb, nr;
    logic [7:0] exp_val;
    code_mem[0] = 8'h0F; code_mem[1] = 8'h0A; code_mem[2] = 8'h72; code_mem[3] = 8'h3F;
    code_mem[10] = 8'h99; data_mem[10] = 8'h42;
    do_reset();
    do_step(nb, nr);
    do_step(nb, nr);
    checks++;
    if ({sp, exec_stack_top, exec_stack_belowtop} !== {5'd2, 8'h0A, 8'h0F}) begin
      errors++;
      $display("FAIL read_setup: sp=%h top=%h below=%h, required 02/0a/0f", sp, exec_stack_top, exec_stack_belowtop);
    end
    sp_inc = 5'd0; st_wcount = 2'd0;
    for (int k = 0; k < 2; k++) begin
      exp_val = (k == 0) ? 8'h42 : 8'h99;
      step = 1'b1;
      tick();
      step = 1'b0;
      tick(); tick();
      checks++;
      if ({mem_req, mem_we, mem_type_data, mem_addr} !== {2'b10, (k == 0), 8'h0A}) begin
        errors++;
        $display("FAIL read_req%0d: req/we/type/addr=%b%b%b/%h, required 10%0d/0a", k, mem_req, mem_we, mem_type_data, mem_addr, (k == 0));
      end
      tick(); tick();
      checks++;
      if (exec_memory_input !== exp_val) begin
        errors++;
        $display("FAIL read_operand%0d: got %h, required %h", k, exec_memory_input, exp_val);
      end
      wait_idle(20);
    end
    sp_inc = 5'd1; st_wcount = 2'd1;
  endtask

  task automatic test_write();
    code_mem[0] = 8'h01; code_mem[1] = 8'h01;
    st_mwe = 1'b1; st_waddr = 8'h20; st_wdata = 8'h5A; st_wtype = 1'b1;
    data_mem[8'h20] = 8'h00;
    wr_lat = 3;
    do_reset();
    run = 1'b1;
    tick(); tick(); tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({mem_req, mem_we, mem_type_data, mem_addr, mem_wdata} !== {3'b111, 8'h20, 8'h5A}) begin
        errors++;
        $display("FAIL write_hold%0d: %b%b%b/%h/%h, required 111/20/5a", i, mem_req, mem_we, mem_type_data, mem_addr, mem_wdata);
      end
      if (i == 0) begin
        checks++;
        if ({pc, sp} !== {8'h01, 5'd1}) begin
          errors++;
          $display("FAIL write_commit: pc=%h sp=%h, required 01/01", pc, sp);
        end
      end
    end
    tick();
    checks++;
    if ({mem_req, mem_we, mem_addr} !== {2'b10, 8'h01}) begin
      errors++;
      $display("FAIL write_refetch: req=%b we=%b addr=%h, required 1/0/01", mem_req, mem_we, mem_addr);
    end
    checks++;
    if (data_mem[8'h20] !== 8'h5A) begin
      errors++;
      $display("FAIL write_data: memory holds %h, required 5a", data_mem[8'h20]);
    end
    run = 1'b0; st_mwe = 1'b0; wr_lat = 1;
    wait_idle(20);
  endtask

  task automatic test_delay_step();
    int nb, nr;
    code_mem[0] = 8'h01; code_mem[1] = 8'h01; code_mem[2] = 8'h01;
    do_reset();
    st_delay = 8'd3;
    do_step(nb, nr);
    checks++;
    if (nb !== 15 || nr !== 2 || pc !== 8'h01) begin
      errors++;
      $display("FAIL delay3: busy=%0d req=%0d pc=%h, required 15/2/01", nb, nr, pc);
    end
    st_delay = 8'd0;
    do_step(nb, nr);
    checks++;
    if (nb !== 3 || nr !== 2 || pc !== 8'h02) begin
      errors++;
      $display("FAIL delay0: busy=%0d req=%0d pc=%h, required 3/2/02", nb, nr, pc);
    end
    step = 1'b1; tick();
    step = 1'b0; tick();
    step = 1'b1; tick();
    step = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if ({busy, pc} !== {1'b0, 8'h03}) begin
      errors++;
      $display("FAIL step_ignored: busy=%b pc=%h, required 0/03", busy, pc);
    end
  endtask

  task automatic test_sleep();
    code_mem[0] = 8'h01; code_mem[1] = 8'h01;
    st_sleep = 1'b1;
    do_reset();
    run = 1'b1;
    tick(); tick(); tick(); tick();
    checks++;
    if ({sleeping, busy, mem_req, pc} !== {3'b100, 8'h01}) begin
      errors++;
      $display("FAIL sleep_enter: sleeping=%b busy=%b req=%b pc=%h, required 1/0/0/01", sleeping, busy, mem_req, pc);
    end
    st_sleep = 1'b0;
    tick(); tick(); tick(); tick();
    checks++;
    if (sleeping !== 1'b1) begin
      errors++;
      $display("FAIL sleep_hold: sleeping=%b, required 1", sleeping);
    end
    wake = 1'b1;
    tick();
    wake = 1'b0;
    checks++;
    if ({sleeping, mem_req, mem_addr} !== {2'b01, 8'h01}) begin
      errors++;
      $display("FAIL wake_fetch: sleeping=%b req=%b addr=%h, required 0/1/01", sleeping, mem_req, mem_addr);
    end
    st_sleep = 1'b1;
    tick(); tick(); tick();
    checks++;
    if ({sleeping, pc} !== {1'b1, 8'h02}) begin
      errors++;
      $display("FAIL sleep_again: sleeping=%b pc=%h, required 1/02", sleeping, pc);
    end
    run = 1'b0;
    tick();
    checks++;
    if ({sleeping, busy, pc} !== {2'b00, 8'h02}) begin
      errors++;
      $display("FAIL sleep_to_idle: sleeping=%b busy=%b pc=%h, required 0/0/02", sleeping, busy, pc);
    end
    st_sleep = 1'b0;
  endtask

  task automatic test_stack_wrap();
    int nb, nr;
    code_mem[0] = 8'h33; code_mem[1] = 8'h44;
    do_reset();
    sp_inc = 5'd30; st_wcount = 2'd3; bt_val = 8'hEE;
    do_step(nb, nr);
    checks++;
    if ({sp, exec_stack_top, exec_stack_belowtop} !== {5'd30, 8'h33, 8'hEE}) begin
      errors++;
      $display("FAIL wcount3: sp=%h top=%h below=%h, required 1e/33/ee", sp, exec_stack_top, exec_stack_belowtop);
    end
    sp_inc = 5'd2; st_wcount = 2'd2; bt_val = 8'hDD;
    do_step(nb, nr);
    checks++;
    if ({sp, exec_stack_top, exec_stack_belowtop} !== {5'd0, 8'h44, 8'hDD}) begin
      errors++;
      $display("FAIL sp_wrap: sp=%h top=%h below=%h, required 00/44/dd", sp, exec_stack_top, exec_stack_belowtop);
    end
    sp_inc = 5'd1; st_wcount = 2'd1; bt_val = 8'hEE;
  endtask

  task automatic test_reset_mid();
    code_mem[0] = 8'h01; code_mem[1] = 8'h01;
    do_reset();
    run = 1'b1;
    tick(); tick(); tick(); tick();
    ack_block = 1'b1;
    tick();
    rst_n = 1'b0; run = 1'b0;
    tick();
    checks++;
    if ({mem_req, busy, pc, sp} !== {2'b00, 8'h00, 5'd0}) begin
      errors++;
      $display("FAIL reset_abort: req=%b busy=%b pc=%h sp=%h, required 0/0/00/00", mem_req, busy, pc, sp);
    end
    rst_n = 1'b1; ack_block = 1'b0; stray_ack = 1'b1;
    tick();
    stray_ack = 1'b0;
    tick();
    checks++;
    if ({mem_req, busy, exec_opcode, pc} !== {2'b00, 8'h00, 8'h00}) begin
      errors++;
      $display("FAIL stray_ack: req=%b busy=%b opcode=%h pc=%h, required 0/0/00/00", mem_req, busy, exec_opcode, pc);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      code_mem[i] = 8'h01;
      data_mem[i] = 8'h00;
    end
    test_reset();
    test_run_basic();
    test_read();
    test_write();
    test_delay_step();
    test_sleep();
    test_stack_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", checks, errors);
    $finish;
  end

endmodule
